// File: rtl/idli_grf_xfer_m.sv
// Parallel-side client of the nibble-serial GPR file: accepts one register read or
// write, aligns it to the nibble rotation phase, streams it over 4 cycles, returns a response.
module idli_grf_xfer_m #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_xfr_gck,
    input  logic              i_xfr_rst_n,
    input  logic              i_xfr_req_vld,
    output logic              o_xfr_req_rdy,
    input  logic              i_xfr_req_wr,
    input  logic [2:0]        i_xfr_req_reg,
    input  logic [DATA_W-1:0] i_xfr_req_data,
    output logic              o_xfr_rsp_vld,
    input  logic              i_xfr_rsp_rdy,
    output logic [DATA_W-1:0] o_xfr_rsp_data,
    output logic [1:0]        o_xfr_phase,
    output logic [2:0]        o_xfr_grf_a,
    output logic              o_xfr_grf_a_vld,
    output logic [3:0]        o_xfr_grf_a_data,
    output logic [2:0]        o_xfr_grf_b,
    input  logic [3:0]        i_xfr_grf_b_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          phase_q;
    logic                wr_q;
    logic [2:0]          reg_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   rsp_q;
    logic                accept;

    assign accept         = (state_q == ST_IDLE) && i_xfr_req_vld;
    assign o_xfr_phase    = phase_q;
    assign o_xfr_rsp_data = rsp_q;

    always_ff @(posedge i_xfr_gck or negedge i_xfr_rst_n) begin
        if (!i_xfr_rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            wr_q    <= 1'b0;
            reg_q   <= '0;
            data_q  <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_q + 2'd1;
            if (accept) begin
                wr_q   <= i_xfr_req_wr;
                reg_q  <= i_xfr_req_reg;
                data_q <= i_xfr_req_data;
            end
            // Reads assemble nibble by nibble; writes echo the captured data once streamed.
            if (state_q == ST_XFER) begin
                if (!wr_q) begin
                    rsp_q[{phase_q, 2'b00} +: 4] <= i_xfr_grf_b_data;
                end else if (phase_q == 2'd3) begin
                    rsp_q <= data_q;
                end
            end
        end
    end

    // GRF strobes are decoded from state so an asynchronous reset drops them at once.
    always_comb begin
        state_d          = state_q;
        o_xfr_req_rdy    = 1'b0;
        o_xfr_rsp_vld    = 1'b0;
        o_xfr_grf_a      = '0;
        o_xfr_grf_b      = '0;
        o_xfr_grf_a_vld  = 1'b0;
        o_xfr_grf_a_data = '0;
        unique case (state_q)
            ST_IDLE: begin
                o_xfr_req_rdy = 1'b1;
                if (i_xfr_req_vld) begin
                    state_d = (phase_q == 2'd3) ? ST_XFER : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (phase_q == 2'd3) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                o_xfr_grf_a      = reg_q;
                o_xfr_grf_b      = reg_q;
                o_xfr_grf_a_vld  = wr_q;
                o_xfr_grf_a_data = wr_q ? data_q[{phase_q, 2'b00} +: 4] : 4'h0;
                if (phase_q == 2'd3) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                o_xfr_rsp_vld = 1'b1;
                if (i_xfr_rsp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_idli_grf_xfer_m.sv
// Self-checking bench for idli_grf_xfer_m: directed scenarios plus randomized
// transactions against a transaction-level register model and a simple GRF model.
module tb_idli_grf_xfer_m;

    logic        clk;
    logic        rst_n;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wr;
    logic [2:0]  req_reg;
    logic [15:0] req_data;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [15:0] rsp_data;
    logic [1:0]  phase;
    logic [2:0]  grf_a;
    logic        grf_a_vld;
    logic [3:0]  grf_a_data;
    logic [2:0]  grf_b;
    logic [3:0]  grf_b_data;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [8];
    logic [15:0] ref_regs [8];
    int unsigned cyc_cnt;

    idli_grf_xfer_m #(.DATA_W(16)) dut (
        .i_xfr_gck        (clk),
        .i_xfr_rst_n      (rst_n),
        .i_xfr_req_vld    (req_vld),
        .o_xfr_req_rdy    (req_rdy),
        .i_xfr_req_wr     (req_wr),
        .i_xfr_req_reg    (req_reg),
        .i_xfr_req_data   (req_data),
        .o_xfr_rsp_vld    (rsp_vld),
        .i_xfr_rsp_rdy    (rsp_rdy),
        .o_xfr_rsp_data   (rsp_data),
        .o_xfr_phase      (phase),
        .o_xfr_grf_a      (grf_a),
        .o_xfr_grf_a_vld  (grf_a_vld),
        .o_xfr_grf_a_data (grf_a_data),
        .o_xfr_grf_b      (grf_b),
        .i_xfr_grf_b_data (grf_b_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycles elapsed since reset release; the expected phase is this count mod 4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_cnt <= 0;
        else        cyc_cnt <= cyc_cnt + 1;
    end

    // GRF stand-in: nibble-serial storage with no reset, R0 hardwired to zero.
    always @(posedge clk) begin
        if (grf_a_vld) mem[grf_a][{phase, 2'b00} +: 4] <= grf_a_data;
    end
    assign grf_b_data = (grf_b == 3'd0) ? 4'h0 : mem[grf_b][{phase, 2'b00} +: 4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("phase", 32'(phase), 32'(cyc_cnt % 4));
    endtask

    task automatic check_idle_grf(input string tag);
        check({tag, "_grf_a"}, 32'(grf_a), 32'd0);
        check({tag, "_grf_b"}, 32'(grf_b), 32'd0);
        check({tag, "_a_vld"}, 32'(grf_a_vld), 32'd0);
        check({tag, "_a_data"}, 32'(grf_a_data), 32'd0);
    endtask

    // One complete request/response; want_ph < 0 means accept at whatever phase comes.
    task automatic xfer(input logic wr, input logic [2:0] r, input logic [15:0] d,
                        input int want_ph, input int hold);
        int k;
        int ph;
        int lat;
        int x0;
        logic [15:0] exp_d;
        bit seen;
        k = 0;
        while (want_ph >= 0 && int'(cyc_cnt % 4) != want_ph && k < 8) begin
            step();
            k++;
        end
        check("accept_rdy", 32'(req_rdy), 32'd1);
        ph       = int'(cyc_cnt % 4);
        req_vld  = 1'b1;
        req_wr   = wr;
        req_reg  = r;
        req_data = d;
        step();
        req_vld  = 1'b0;
        req_wr   = 1'($urandom);
        req_reg  = 3'($urandom);
        req_data = 16'($urandom);
        lat = 5 + ((3 - ph) & 3);
        x0  = lat - 4;
        if (wr) begin
            exp_d = d;
            ref_regs[r] = d;
        end else begin
            exp_d = (r == 3'd0) ? 16'h0000 : ref_regs[r];
        end
        k = 1;
        seen = 0;
        while (k <= 12 && !seen) begin
            if (rsp_vld) begin
                seen = 1;
            end else begin
                check("busy_rdy", 32'(req_rdy), 32'd0);
                if (k >= x0 && k < x0 + 4) begin
                    check("xfer_grf_a", 32'(grf_a), 32'(r));
                    check("xfer_grf_b", 32'(grf_b), 32'(r));
                    check("xfer_a_vld", 32'(grf_a_vld), 32'(wr));
                    if (wr) check("xfer_a_data", 32'(grf_a_data), 32'(d[4*(k-x0) +: 4]));
                end else begin
                    check_idle_grf("wait");
                end
                step();
                k++;
            end
        end
        check("rsp_latency", 32'(k), 32'(lat));
        check("rsp_data", 32'(rsp_data), 32'(exp_d));
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_vld", 32'(rsp_vld), 32'd1);
            check("hold_data", 32'(rsp_data), 32'(exp_d));
            check("hold_rdy", 32'(req_rdy), 32'd0);
            check("hold_a_vld", 32'(grf_a_vld), 32'd0);
        end
        rsp_rdy = 1'b1;
        step();
        rsp_rdy = 1'b0;
        check("post_rsp_vld", 32'(rsp_vld), 32'd0);
        check("post_req_rdy", 32'(req_rdy), 32'd1);
    endtask

    initial begin
        int k;
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            mem[i]      = 16'($urandom);
            ref_regs[i] = 16'h0000;
        end
        rst_n    = 1'b0;
        req_vld  = 1'b0;
        req_wr   = 1'b0;
        req_reg  = '0;
        req_data = '0;
        rsp_rdy  = 1'b0;

        // Reset state and free-running phase
        #12;
        rst_n = 1'b1;
        #1;
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_req_rdy", 32'(req_rdy), 32'd1);
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_idle_grf("rst");
        for (int i = 0; i < 5; i++) begin
            step();
            check("run_req_rdy", 32'(req_rdy), 32'd1);
            check("run_rsp_vld", 32'(rsp_vld), 32'd0);
            check_idle_grf("run");
        end

        // Directed: phase-aligned write, reads at each misaligned phase, R0, back-pressure
        xfer(1'b1, 3'd3, 16'hBEEF, 3, 0);
        xfer(1'b0, 3'd3, 16'h0000, 0, 0);
        xfer(1'b0, 3'd3, 16'h0000, 1, 0);
        xfer(1'b0, 3'd3, 16'h0000, 2, 0);
        xfer(1'b1, 3'd0, 16'h1234, -1, 0);
        xfer(1'b0, 3'd0, 16'h0000, -1, 0);
        xfer(1'b0, 3'd3, 16'h0000, -1, 10);

        // Reset during XFER at phase 1
        req_vld  = 1'b1;
        req_wr   = 1'b1;
        req_reg  = 3'd5;
        req_data = 16'hA5C3;
        step();
        req_vld = 1'b0;
        k = 0;
        while (!(grf_a_vld && phase == 2'd1) && k < 12) begin
            step();
            k++;
        end
        check("midrst_reached", 32'(grf_a_vld && phase == 2'd1), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_a_vld", 32'(grf_a_vld), 32'd0);
        check("midrst_phase", 32'(phase), 32'd0);
        check("midrst_req_rdy", 32'(req_rdy), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("postrst_phase", 32'(phase), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("postrst_rsp_vld", 32'(rsp_vld), 32'd0);
            check("postrst_req_rdy", 32'(req_rdy), 32'd1);
        end

        // Register contents are undefined after reset: rewrite all before reading
        for (int r = 1; r < 8; r++) begin
            xfer(1'b1, 3'(r), 16'($urandom), -1, 0);
        end
        xfer(1'b0, 3'd5, 16'h0000, -1, 0);

        // Randomized mix
        for (int n = 0; n < 60; n++) begin
            v = 16'($urandom);
            xfer(1'($urandom), 3'($urandom_range(0, 7)), v,
                 int'($urandom_range(0, 4)) - 1, int'($urandom_range(0, 3)));
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
